// File: rtl/filter_pkg.sv
// Shared defaults and helpers for the per-bit debounce filter.
package filter_pkg;

  localparam int DEF_NUM_SIGNALS  = 16;
  localparam int DEF_FILTER_WIDTH = 4;
  localparam int MAX_SIGNALS      = 256;

  // Idle level of the filtered bus: the low n bits set, the rest clear.
  function automatic logic [MAX_SIGNALS-1:0] out_default(input int n);
    logic [MAX_SIGNALS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_SIGNALS; i++) begin
      r[i] = (i < n);
    end
    return r;
  endfunction

endpackage

// File: rtl/filter_bit.sv
// One debounce channel. The output takes the input's value once the two have
// disagreed for 2^FILTER_WIDTH consecutive cycles.
module filter_bit
  import filter_pkg::*;
#(
  parameter int   FILTER_WIDTH = DEF_FILTER_WIDTH,
  parameter logic RST_BIT      = 1'b1
) (
  input  logic clk,
  input  logic aclr,
  input  logic in,
  output logic out
);

  localparam logic [FILTER_WIDTH-1:0] CNT_LAST = '1;

  logic [FILTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                    out_q, out_d;

  // Any agreeing cycle discards the whole run. Reaching the terminal count
  // flips the output and clears the counter, so it can never wrap.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (in != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = in;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      cnt_q <= '0;
      out_q <= RST_BIT;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/filter.sv
// Bus debounce filter: NUM_SIGNALS independent filter_bit channels. The
// outputs idle high.
module filter
  import filter_pkg::*;
#(
  parameter int NUM_SIGNALS  = DEF_NUM_SIGNALS,
  parameter int FILTER_WIDTH = DEF_FILTER_WIDTH
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic [NUM_SIGNALS-1:0] in,
  output logic [NUM_SIGNALS-1:0] out
);

  localparam logic [NUM_SIGNALS-1:0] RST_VAL = NUM_SIGNALS'(out_default(NUM_SIGNALS));

  for (genvar g = 0; g < NUM_SIGNALS; g++) begin : g_bit
    filter_bit #(
      .FILTER_WIDTH (FILTER_WIDTH),
      .RST_BIT      (RST_VAL[g])
    ) u_bit (
      .clk  (clk),
      .aclr (aclr),
      .in   (in[g]),
      .out  (out[g])
    );
  end

endmodule

// File: tb/tb_filter.sv
// Directed bench for the debounce filter at its default sizes (16 bits, depth 16).
module tb_filter;

  logic        clk;
  logic        aclr;
  logic [15:0] din;
  logic [15:0] dout;

  int compared;
  int mismatched;

  filter #(.NUM_SIGNALS(16), .FILTER_WIDTH(4)) dut (
    .clk  (clk),
    .aclr (aclr),
    .in   (din),
    .out  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    compared++;
    assert (dout === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, dout, exp);
    end
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    step();
    aclr = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    aclr       = 1'b1;
    din        = 16'hFFFF;

    // Reset state.
    step();
    check("reset", 16'hFFFF);
    aclr = 1'b0;

    // Idle high.
    for (int c = 0; c < 40; c++) begin
      step();
      check($sformatf("idle_c%0d", c), 16'hFFFF);
    end

    // All bits fall together.
    din = 16'h0000;
    for (int e = 1; e <= 15; e++) begin
      step();
      check($sformatf("all_hold_e%0d", e), 16'hFFFF);
    end
    step();
    check("all_fall_e16", 16'h0000);

    // Return path, clean run.
    din = 16'hFFFF;
    for (int e = 1; e <= 15; e++) begin
      step();
      check($sformatf("ret_hold_e%0d", e), 16'h0000);
    end
    step();
    check("ret_rise_e16", 16'hFFFF);

    // Back to zero, then a return with a one-cycle 0 sampled on edge 8.
    din = 16'h0000;
    for (int e = 1; e <= 16; e++) step();
    check("ret2_low", 16'h0000);
    for (int e = 1; e <= 23; e++) begin
      din = (e == 8) ? 16'h0000 : 16'hFFFF;
      step();
      check($sformatf("ret_glitch_hold_e%0d", e), 16'h0000);
    end
    din = 16'hFFFF;
    step();
    check("ret_glitch_rise_e24", 16'hFFFF);

    // Reset pulse from the low state.
    din = 16'h0000;
    for (int e = 1; e <= 16; e++) step();
    check("pre_aclr_low", 16'h0000);
    do_reset();
    check("aclr_pulse", 16'hFFFF);
    din = 16'hFFFF;
    step();
    check("after_aclr", 16'hFFFF);

    // Walking zero.
    for (int i = 0; i < 16; i++) begin
      din = 16'hFFFF ^ (16'h0001 << i);
      for (int e = 1; e <= 15; e++) step();
      check($sformatf("walk%0d_e15", i), 16'hFFFF);
      step();
      check($sformatf("walk%0d_e16", i), din);
      do_reset();
      check($sformatf("walk%0d_aclr", i), 16'hFFFF);
    end

    // Glitch inside a run. Bits low in both patterns (A982) keep counting and
    // fall on edge 16; bits the glitch pushes back high (4449) restart and
    // fall 16 edges after the glitch edge.
    for (int s = 1; s <= 14; s++) begin
      for (int e = 0; e < 15; e++) begin
        din = (e == s) ? 16'h466D : 16'h1234;
        step();
        check($sformatf("gl%0d_hold_e%0d", s, e), 16'hFFFF);
      end
      din = 16'h1234;
      for (int e = 0; e <= s; e++) begin
        step();
        check($sformatf("gl%0d_part_%0d", s, e), 16'h567D);
      end
      step();
      check($sformatf("gl%0d_done", s), 16'h1234);
      do_reset();
      check($sformatf("gl%0d_aclr", s), 16'hFFFF);
    end

    // Reset beats terminal count.
    din = 16'h0000;
    for (int e = 1; e <= 15; e++) step();
    check("prio_e15", 16'hFFFF);
    aclr = 1'b1;
    step();
    check("prio_aclr_e16", 16'hFFFF);
    aclr = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      check($sformatf("prio_refill_e%0d", e), 16'hFFFF);
    end
    step();
    check("prio_fall", 16'h0000);

    // Reset held high overrides the input.
    din  = 16'h0000;
    aclr = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("aclr_held_c%0d", c), 16'hFFFF);
    end
    aclr = 1'b0;
    din  = 16'h00FF;
    for (int e = 1; e <= 15; e++) step();
    check("post_held_e15", 16'hFFFF);
    step();
    check("post_held_e16", 16'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/filter.md
# filter

Per-bit digital debounce filter for a bus of slow control signals (commands). Each output bit follows its input bit only after the input has differed from the current output for 2^FILTER_WIDTH consecutive clock cycles. Any cycle of agreement restarts the count. It sits between raw command inputs and downstream decoding logic, suppressing glitches and short pulses. Outputs are idle-high (all ones).

## Interface
- NUM_SIGNALS, default 16: number of independently filtered bits.
- FILTER_WIDTH, default 4: width of each per-bit counter; filter depth N = 2^FILTER_WIDTH cycles (16 at default).
- clk  in  1  system clock; all state updates on rising edge.
- aclr  in  1  reset; one clock, reset is synchronous and active-high; sampled on rising clk edge.
- in  in  NUM_SIGNALS  raw input bits, synchronous to clk.
- out  out  NUM_SIGNALS  filtered bits, registered.

## Operation
- Each bit i has an independent filter: registered out[i] and FILTER_WIDTH-bit counter cnt[i].
- On each rising edge, in priority order:
  - If aclr=1: out <= all ones, every cnt <= 0.
  - Else, per bit:
    - If in[i] == out[i]: cnt[i] <= 0, out[i] holds.
    - Else if cnt[i] == N-1: out[i] <= in[i], cnt[i] <= 0.
    - Else: cnt[i] <= cnt[i]+1, out[i] holds.
- Filtering is symmetric: 1→0 and 0→1 transitions both require N consecutive disagreeing cycles.
- A single agreeing cycle anywhere in the run fully restarts that bit's count. There is no partial credit and no down-counting.
- Bits never interact; a glitch on one bit does not affect the timing of others.
- Counter arithmetic is unsigned FILTER_WIDTH bits. The count never wraps, because the terminal value N-1 always triggers the transition and a clear to 0.

## Timing
- Reset value: out = {NUM_SIGNALS{1'b1}}, counters 0; valid from the first edge with aclr=1.
- Latency: a bit stable at the new value from before edge 1 changes out on edge N (16th edge at default). After edges 1..N-1, out still shows the old value.
- No combinational path from in to out.
- Glitch at cycle k of a run: the count restarts after k. The output changes N edges after the glitch cycle, i.e. at edge k+1+N counted from the start of the run.
- Reset mid-count: all progress is discarded; out returns to all ones on that edge.
- aclr held high: out is held at all ones regardless of in.
- Simultaneous aclr and terminal count: reset wins.

## Structure
- Shared package filter_pkg: default parameter values and function out_default(NUM_SIGNALS) returning all ones.
- One sub-module, filter_bit (parameter FILTER_WIDTH; ports clk, aclr, in, out), holding one counter and one output flop.
- Top Filter instantiates NUM_SIGNALS filter_bit instances in a generate loop.

## Test plan
- Idle: after reset with in=FFFF, out=FFFF and stays FFFF for 40 cycles.
- All bits: in=0000 held; out=FFFF after edges 1..15, out=0000 at edge 16; then aclr pulse (one edge) → out=FFFF.
- Walking zero: for each i in 0..15, in=FFFF^(1<<i); out=FFFF through edge 15 and equals in at edge 16; aclr → FFFF.
- Glitch, for step_err=1..14:
  - Apply in=1234 for 15 edges, except in=466D on edge step_err → out=FFFF throughout.
  - Continue in=1234 for step_err+1 edges → out=567D on each.
  - One more edge → out=1234.
  - aclr → FFFF.
- Return path: after out=0000, set in=FFFF; out stays 0000 for 15 edges and becomes FFFF on the 16th. A one-cycle 0 at edge 8 delays the change by 8 edges.
- Reset priority: in=0000 for 15 edges, then aclr=1 on edge 16 → out=FFFF. Deassert aclr; out needs a further full 16 edges to reach 0000.
